// File: rtl/ar_pkg.sv
// Shared AXI read-address constants and the request-entry layout held in the issue FIFO.
package ar_pkg;

    localparam int          AXI_ADDR_W     = 32;
    localparam int          AXI_ID_W       = 4;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

    // One buffered request; the source index is stored already widened to the AXI ID width.
    typedef struct packed {
        logic [AXI_ID_W-1:0]   src;
        logic [AXI_ADDR_W-1:0] addr;
        logic [1:0]            size;
        logic [7:0]            len;
    } req_entry_t;

endpackage

// File: rtl/ar_issue_queue_if.sv
// Request side, AR channel and R-channel observation bundled for the issue queue.
interface ar_issue_queue_if #(
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC-1:0]    req_valid;
    logic [NUM_SRC*32-1:0] req_addr;
    logic [NUM_SRC*2-1:0]  req_size;
    logic [NUM_SRC*8-1:0]  req_len;
    logic [NUM_SRC-1:0]    addr_ok;
    logic                  writing;

    logic [3:0]            arid;
    logic [31:0]           araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [1:0]            arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic                  rvalid;
    logic                  rready;
    logic                  rlast;
    logic [3:0]            outst_cnt;

    // The issue queue itself: accepts requests and masters the AR channel.
    modport master (
        input  req_valid, req_addr, req_size, req_len, writing,
        input  arready, rvalid, rready, rlast,
        output addr_ok,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output outst_cnt
    );

    // The environment: request sources plus the AXI slave.
    modport slave (
        output req_valid, req_addr, req_size, req_len, writing,
        output arready, rvalid, rready, rlast,
        input  addr_ok,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  outst_cnt
    );
endinterface

// File: rtl/ar_fifo.sv
// Synchronous FIFO with power-of-two depth; head entry is visible on dout while not empty.
module ar_fifo #(
    parameter int WIDTH = 46,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];

    // Storage array write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/ar_issue_queue.sv
// Fixed-priority request arbiter feeding an in-order AXI AR issue FIFO with an outstanding-burst limit.
module ar_issue_queue
    import ar_pkg::*;
#(
    parameter int               NUM_SRC     = 2,
    parameter int               FIFO_DEPTH  = 4,
    parameter int               MAX_OUTST   = 4,
    parameter logic [NUM_SRC-1:0] HAZARD_MASK = NUM_SRC'(2'b10)
) (
    input  logic             clk,
    input  logic             reset,
    ar_issue_queue_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = $bits(req_entry_t);

    logic [NUM_SRC-1:0] grant_s;
    logic               found_s;
    req_entry_t         entry_in_s;
    req_entry_t         entry_out_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CW-1:0]      fifo_count_s;
    logic               room_s;
    logic               push_s;
    logic               ar_valid_s;
    logic               ar_hs_s;
    logic               r_done_s;
    logic [3:0]         outst_cnt_r;

    // Lowest-index eligible source wins; sources in the hazard mask sit out while a write is in flight.
    always_comb begin
        grant_s    = {NUM_SRC{1'b0}};
        found_s    = 1'b0;
        entry_in_s = {EW{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.req_valid[i] && !(bus.writing && HAZARD_MASK[i]) && !found_s) begin
                grant_s[i]      = 1'b1;
                found_s         = 1'b1;
                entry_in_s.src  = AXI_ID_W'(i);
                entry_in_s.addr = bus.req_addr[i*AXI_ADDR_W +: AXI_ADDR_W];
                entry_in_s.size = bus.req_size[i*2 +: 2];
                entry_in_s.len  = bus.req_len[i*8 +: 8];
            end else begin
                grant_s[i] = 1'b0;
            end
        end
    end

    // Acceptance depends only on buffer occupancy, never on arready, so a same-cycle pop does not free a slot.
    assign room_s      = !fifo_full_s && (fifo_count_s < CW'(FIFO_DEPTH));
    assign bus.addr_ok = (room_s && !reset) ? grant_s : {NUM_SRC{1'b0}};
    assign push_s      = |(bus.req_valid & bus.addr_ok);

    ar_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   (entry_in_s),
        .pop   (ar_hs_s),
        .dout  (entry_out_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // arvalid cannot drop before its handshake because the outstanding count only rises on a handshake.
    assign ar_valid_s = !fifo_empty_s && (outst_cnt_r < 4'(MAX_OUTST));
    assign ar_hs_s    = ar_valid_s && bus.arready;
    assign r_done_s   = bus.rvalid && bus.rready && bus.rlast && (outst_cnt_r != 4'd0);

    // Outstanding bursts: +1 on AR handshake, -1 on a completed last beat, unchanged when both coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outst_cnt_r <= 4'd0;
        end else begin
            case ({ar_hs_s, r_done_s})
                2'b10:   outst_cnt_r <= outst_cnt_r + 4'd1;
                2'b01:   outst_cnt_r <= outst_cnt_r - 4'd1;
                default: outst_cnt_r <= outst_cnt_r;
            endcase
        end
    end

    assign bus.arvalid   = ar_valid_s;
    assign bus.arid      = entry_out_s.src;
    assign bus.araddr    = entry_out_s.addr;
    assign bus.arlen     = entry_out_s.len;
    assign bus.arsize    = {1'b0, entry_out_s.size};
    assign bus.arburst   = AXI_BURST_INCR;
    assign bus.arlock    = 2'b00;
    assign bus.arcache   = 4'b0000;
    assign bus.arprot    = 3'b000;
    assign bus.outst_cnt = outst_cnt_r;
endmodule

// File: tb/tb_ar_issue_queue.sv
// Directed bench for ar_issue_queue: expected AR beats go into a scoreboard queue, a negedge monitor checks each handshake.
module tb_ar_issue_queue;
    import ar_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ar_issue_queue_if #(.NUM_SRC(2)) bus();

    ar_issue_queue #(
        .NUM_SRC     (2),
        .FIFO_DEPTH  (4),
        .MAX_OUTST   (4),
        .HAZARD_MASK (2'b10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int src, input logic [31:0] addr, input logic [1:0] size, input logic [7:0] len);
        bus.req_addr[src*32 +: 32] = addr;
        bus.req_size[src*2 +: 2]   = size;
        bus.req_len[src*8 +: 8]    = len;
    endtask

    task automatic expect_ar(input int src, input logic [31:0] addr, input logic [1:0] size, input logic [7:0] len);
        exp_t e;
        e.id   = 4'(src);
        e.addr = addr;
        e.len  = len;
        e.size = {1'b0, size};
        sb.push_back(e);
    endtask

    task automatic set_r(input logic v);
        bus.rvalid = v;
        bus.rready = v;
        bus.rlast  = v;
    endtask

    // Scoreboard monitor: every AR handshake must match the oldest expected request.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.arvalid && bus.arready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ar: got araddr 0x%0h arid %0d, expected no AR", bus.araddr, bus.arid);
            end else begin
                e = sb.pop_front();
                check("arid",    64'(bus.arid),    64'(e.id));
                check("araddr",  64'(bus.araddr),  64'(e.addr));
                check("arlen",   64'(bus.arlen),   64'(e.len));
                check("arsize",  64'(bus.arsize),  64'(e.size));
                check("arconst", 64'({bus.arburst, bus.arlock, bus.arcache, bus.arprot}), 64'({2'b01, 2'b00, 4'b0000, 3'b000}));
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_addr  = 64'd0;
        bus.req_size  = 4'd0;
        bus.req_len   = 16'd0;
        bus.writing   = 1'b0;
        bus.arready   = 1'b1;
        set_r(1'b0);
        set_req(0, 32'h0000_1000, 2'd2, 8'd3);
        set_req(1, 32'h0000_2000, 2'd1, 8'd7);
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with both sources requesting.
        bus.req_valid = 2'b11;
        #1;
        check("rst_addr_ok", 64'(bus.addr_ok),   64'd0);
        check("rst_arvalid", 64'(bus.arvalid),   64'd0);
        check("rst_outst",   64'(bus.outst_cnt), 64'd0);

        // Both sources at once: src0 first, src1 next cycle.
        reset = 1'b0;
        #1;
        check("arb_both", 64'(bus.addr_ok), 64'd1);
        expect_ar(0, 32'h0000_1000, 2'd2, 8'd3);
        tick();
        bus.req_valid = 2'b10;
        #1;
        check("arb_second", 64'(bus.addr_ok), 64'd2);
        check("ar_latency", 64'(bus.arvalid), 64'd1);
        expect_ar(1, 32'h0000_2000, 2'd1, 8'd7);
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        check("outst_two",  64'(bus.outst_cnt), 64'd2);
        check("idle_arvalid", 64'(bus.arvalid), 64'd0);
        set_r(1'b1);
        tick();
        tick();
        check("outst_drain", 64'(bus.outst_cnt), 64'd0);
        tick();
        check("outst_no_underflow", 64'(bus.outst_cnt), 64'd0);
        set_r(1'b0);

        // Write hazard blocks src1 until writing drops.
        bus.writing = 1'b1;
        set_req(1, 32'h0000_3000, 2'd0, 8'd0);
        bus.req_valid = 2'b10;
        #1;
        check("haz_block", 64'(bus.addr_ok), 64'd0);
        tick();
        check("haz_block_hold", 64'(bus.addr_ok), 64'd0);
        check("haz_no_arvalid", 64'(bus.arvalid), 64'd0);
        bus.writing = 1'b0;
        #1;
        check("haz_release", 64'(bus.addr_ok), 64'd2);
        expect_ar(1, 32'h0000_3000, 2'd0, 8'd0);
        tick();
        bus.req_valid = 2'b00;
        check("haz_arvalid", 64'(bus.arvalid), 64'd1);
        check("haz_arid",    64'(bus.arid),    64'd1);
        tick();
        tick();
        check("haz_outst", 64'(bus.outst_cnt), 64'd1);
        set_r(1'b1);
        tick();
        set_r(1'b0);
        check("haz_outst_done", 64'(bus.outst_cnt), 64'd0);

        // Fill the FIFO with arready low; fifth request refused, head payload stable.
        bus.arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(0, 32'h0000_4000 + 32'(16 * i), 2'd0, 8'(i));
            bus.req_valid = 2'b01;
            #1;
            if (i < 4) begin
                check("fill_accept", 64'(bus.addr_ok), 64'd1);
                expect_ar(0, 32'h0000_4000 + 32'(16 * i), 2'd0, 8'(i));
            end else begin
                check("full_block", 64'(bus.addr_ok), 64'd0);
            end
            if (i > 0) begin
                check("stable_arvalid", 64'(bus.arvalid), 64'd1);
                check("stable_araddr",  64'(bus.araddr),  64'h4000);
                check("stable_arlen",   64'(bus.arlen),   64'd0);
            end
            tick();
        end

        // Full FIFO with a pop this cycle still refuses; accepts the cycle after.
        set_req(0, 32'h0000_5000, 2'd3, 8'd9);
        bus.req_valid = 2'b01;
        bus.arready   = 1'b1;
        #1;
        check("full_pop_block", 64'(bus.addr_ok), 64'd0);
        tick();
        #1;
        check("full_resume", 64'(bus.addr_ok), 64'd1);
        expect_ar(0, 32'h0000_5000, 2'd3, 8'd9);
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        tick();

        // Outstanding limit reached with an entry still buffered.
        check("max_outst",   64'(bus.outst_cnt), 64'd4);
        check("max_stall",   64'(bus.arvalid),   64'd0);
        set_r(1'b1);
        tick();
        set_r(1'b0);
        check("max_release_cnt", 64'(bus.outst_cnt), 64'd3);
        check("max_release",     64'(bus.arvalid),   64'd1);
        tick();
        check("max_again",   64'(bus.outst_cnt), 64'd4);
        check("fifo_empty",  64'(bus.arvalid),   64'd0);

        // Simultaneous AR handshake and rlast at a count of two.
        set_r(1'b1);
        tick();
        tick();
        set_r(1'b0);
        bus.arready = 1'b0;
        set_req(1, 32'h0000_6000, 2'd2, 8'd15);
        bus.req_valid = 2'b10;
        #1;
        check("sim_accept", 64'(bus.addr_ok), 64'd2);
        expect_ar(1, 32'h0000_6000, 2'd2, 8'd15);
        tick();
        bus.req_valid = 2'b00;
        check("sim_pre_cnt",     64'(bus.outst_cnt), 64'd2);
        check("sim_pre_arvalid", 64'(bus.arvalid),   64'd1);
        bus.arready = 1'b1;
        set_r(1'b1);
        tick();
        set_r(1'b0);
        check("sim_hs_rlast", 64'(bus.outst_cnt), 64'd2);
        set_r(1'b1);
        tick();
        tick();
        set_r(1'b0);
        check("sim_drain", 64'(bus.outst_cnt), 64'd0);

        // Reset mid-transfer: one burst outstanding, three buffered.
        set_req(0, 32'h0000_7000, 2'd1, 8'd1);
        bus.req_valid = 2'b01;
        #1;
        expect_ar(0, 32'h0000_7000, 2'd1, 8'd1);
        tick();
        bus.req_valid = 2'b00;
        tick();
        bus.arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 32'h0000_8000 + 32'(16 * i), 2'd0, 8'd0);
            bus.req_valid = 2'b01;
            tick();
        end
        check("rst_pre_arvalid", 64'(bus.arvalid),   64'd1);
        check("rst_pre_outst",   64'(bus.outst_cnt), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_arvalid", 64'(bus.arvalid),   64'd0);
        check("rst_async_outst",   64'(bus.outst_cnt), 64'd0);
        check("rst_async_addr_ok", 64'(bus.addr_ok),   64'd0);
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.req_valid = 2'b00;
        bus.arready   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_stale_ar", 64'(bus.arvalid), 64'd0);
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ar_issue_queue.md
AR_ISSUE_QUEUE -- requirements
Module: ar_issue_queue

Interface
REQ-001 Parameter NUM_SRC, default 2, number of requesting sources (index 0 = highest priority).
REQ-002 Parameter FIFO_DEPTH, default 4, request buffer entries (power of two, >=2).
REQ-003 Parameter MAX_OUTST, default 4, maximum AXI read bursts issued but not completed (1..15).
REQ-004 Parameter HAZARD_MASK, default NUM_SRC'b10, sources blocked while writing is high.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  NUM_SRC  per-source request strobe.
REQ-008 req_addr  in  NUM_SRC*32  per-source byte address.
REQ-009 req_size  in  NUM_SRC*2  per-source log2 bytes per beat.
REQ-010 req_len  in  NUM_SRC*8  per-source beats minus one.
REQ-011 addr_ok  out  NUM_SRC  one-hot request accept; transfer when req_valid[i] & addr_ok[i].
REQ-012 writing  in  1  write in flight; blocks sources in HAZARD_MASK.
REQ-013 arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1  AXI read-address channel.
REQ-014 arready  in  1  AXI slave ready.
REQ-015 rvalid, rready, rlast  in  1 each  R-channel observation for completion counting.
REQ-016 outst_cnt  out  4  current outstanding-burst count.

Function
REQ-017 Eligible source: req_valid[i] & !(writing & HAZARD_MASK[i]); grant lowest eligible index.
REQ-018 addr_ok = one-hot grant when FIFO count < FIFO_DEPTH and reset low; else all zero; combinational, no dependence on arready.
REQ-019 Accepted request pushes {src index, addr, size, len} to FIFO same edge; no push-pop bypass.
REQ-020 FIFO full: addr_ok zero even if same-cycle pop; push resumes the cycle after count drops.
REQ-021 arvalid = FIFO non-empty & outst_cnt < MAX_OUTST; earliest one cycle after acceptance.
REQ-022 Once arvalid high it stays high with stable payload until arvalid & arready (holds because outst_cnt only rises on handshake).
REQ-023 AR handshake pops FIFO head and increments outst_cnt.
REQ-024 rvalid & rready & rlast decrements outst_cnt; simultaneous AR handshake and rlast leaves it unchanged.
REQ-025 rlast with outst_cnt = 0 ignored (no underflow).
REQ-026 Payload from FIFO head: arid = src index zero-extended to 4; araddr = addr; arlen = len; arsize = {1'b0,size}.
REQ-027 Constants: arburst = 2'b01 (INCR), arlock = 0, arcache = 0, arprot = 0.
REQ-028 Requests issued on AR in acceptance order across all sources.
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

Reset
REQ-030 reset asserted: FIFO empty, pointers 0, outst_cnt 0, arvalid 0, addr_ok 0, immediately and asynchronously.
REQ-031 reset mid-transfer discards all buffered and outstanding requests; no AR re-issue after release.
REQ-032 First acceptance possible in the first cycle reset is low at a rising edge.

Structure
REQ-033 Shared package ar_pkg: AXI_BURST_INCR, AXI_ADDR_W = 32, AXI_ID_W = 4, request-entry struct typedef.
REQ-034 Buffer is sub-module ar_fifo (sync FIFO, parametrised width/depth, full/empty/count outputs).
REQ-035 Arbiter, outstanding counter and AR drive live in ar_issue_queue.

Verification
REQ-036 Src0 and src1 valid same cycle, idle bus -> addr_ok = 2'b01; arid 0 first, then 1; both addr/len exact.
REQ-037 writing = 1, only src1 valid (default mask) -> addr_ok = 0; writing drops -> accepted, arid = 1 next cycle.
REQ-038 arready held 0, 5 single requests -> 4 accepted, 5th addr_ok = 0; arvalid payload stable throughout.
REQ-039 MAX_OUTST = 4 reached, no rlast -> arvalid low with FIFO non-empty; one rlast -> arvalid high next cycle.
REQ-040 AR handshake and rlast same cycle at outst_cnt = 2 -> outst_cnt stays 2.
REQ-041 reset pulse with FIFO 3 full, arvalid high -> arvalid, outst_cnt, addr_ok 0 at once; no stale AR after release.
